// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - up/down sweep sequencer for an external counter with registered flags
// Optional build macro: CNT_SHADOW_CHECK_EN (shadow position cross-check against the counter flags)
module counter_sweep_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] sweep_to,
   input  logic [3:0]       num_sweeps,
   input  logic             flag_count_max,
   input  logic             flag_count_min,
   output logic [WIDTH-1:0] count_to,
   output logic             load_en,
   output logic             count_inc,
   output logic             count_dec,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_UP_CHK  = 3'd3;
   localparam logic [2:0] S_UP_STEP = 3'd4;
   localparam logic [2:0] S_DN_CHK  = 3'd5;
   localparam logic [2:0] S_DN_STEP = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [3:0]       rem_q, rem_d;         // sweeps still to complete
   logic [WIDTH-1:0] cto_q, cto_d;         // latched ceiling
   logic             dn_q, dn_d;           // WAIT returns to DN_CHK when set
   logic             from_load_q, from_load_d;  // WAIT entered straight from LOAD

`ifdef CNT_SHADOW_CHECK_EN
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             err_q, err_d;
   logic             mismatch;
`endif

   // Pulses are Moore outputs gated by abort so an abort cycle never steps the counter
   always_comb begin
      load_en   = (state_q == S_LOAD)    && !abort;
      count_inc = (state_q == S_UP_STEP) && !abort;
      count_dec = (state_q == S_DN_STEP) && !abort;
      done      = (state_q == S_DONE)    && !abort;
      busy      = (state_q != S_IDLE);
      count_to  = cto_q;
`ifdef CNT_SHADOW_CHECK_EN
      err       = err_q;
`else
      err       = 1'b0;
`endif
   end

   // Next-state and job bookkeeping
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      cto_d       = cto_q;
      dn_d        = dn_q;
      from_load_d = from_load_q;
`ifdef CNT_SHADOW_CHECK_EN
      shadow_d    = shadow_q;
      err_d       = err_q;
      mismatch    = (flag_count_max != (shadow_q == cto_q)) ||
                    (flag_count_min != (shadow_q == '0));
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cto_d   = sweep_to;
               rem_d   = num_sweeps;
`ifdef CNT_SHADOW_CHECK_EN
               err_d   = 1'b0;
`endif
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            dn_d        = 1'b0;
            from_load_d = 1'b1;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            from_load_d = 1'b0;
            if (from_load_q && (rem_q == 4'd0)) begin
               state_d = S_DONE;
            end else if (dn_q) begin
               state_d = S_DN_CHK;
            end else begin
               state_d = S_UP_CHK;
            end
         end
         S_UP_CHK: begin
            state_d = flag_count_max ? S_DN_CHK : S_UP_STEP;
         end
         S_UP_STEP: begin
            dn_d    = 1'b0;
            state_d = S_WAIT;
         end
         S_DN_CHK: begin
            if (!flag_count_min) begin
               state_d = S_DN_STEP;
            end else begin
               rem_d   = rem_q - 4'd1;
               state_d = (rem_q <= 4'd1) ? S_DONE : S_UP_CHK;
            end
         end
         S_DN_STEP: begin
            dn_d    = 1'b1;
            state_d = S_WAIT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
`ifdef CNT_SHADOW_CHECK_EN
      if (load_en) begin
         shadow_d = '0;
      end else if (count_inc) begin
         shadow_d = shadow_q + 1'b1;
      end else if (count_dec) begin
         shadow_d = shadow_q - 1'b1;
      end
      if (((state_q == S_UP_CHK) || (state_q == S_DN_CHK)) && mismatch) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end
`endif
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
`ifdef CNT_SHADOW_CHECK_EN
         err_d   = err_q;
`endif
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rem_q       <= 4'd0;
         cto_q       <= '0;
         dn_q        <= 1'b0;
         from_load_q <= 1'b0;
`ifdef CNT_SHADOW_CHECK_EN
         shadow_q    <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         cto_q       <= cto_d;
         dn_q        <= dn_d;
         from_load_q <= from_load_d;
`ifdef CNT_SHADOW_CHECK_EN
         shadow_q    <= shadow_d;
         err_q       <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - randomized job bench for counter_sweep_ctrl with an attached up/down counter
module tb_counter_sweep_ctrl;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] sweep_to = '0;
   logic [3:0]       num_sweeps = 4'd0;
   logic             flag_count_max;
   logic             flag_count_min;
   logic [WIDTH-1:0] count_to;
   logic             load_en, count_inc, count_dec, busy, done, err;

   logic [WIDTH-1:0] cnt;
   logic             fmax_q, fmin_q;
   logic             force_max = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   int r_load, r_inc, r_dec, r_done, r_busy, r_done_cyc, r_excl, r_cto_bad;
   int r_abort_pulse, r_end, r_err;
   bit r_fin;

   counter_sweep_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .sweep_to(sweep_to), .num_sweeps(num_sweeps),
      .flag_count_max(flag_count_max), .flag_count_min(flag_count_min),
      .count_to(count_to), .load_en(load_en), .count_inc(count_inc),
      .count_dec(count_dec), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Downstream counter: loads zero, steps on pulses, flags registered one edge later
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         fmax_q <= 1'b0;
         fmin_q <= 1'b0;
      end else begin
         if (load_en)        cnt <= '0;
         else if (count_inc) cnt <= cnt + 1'b1;
         else if (count_dec) cnt <= cnt - 1'b1;
         fmax_q <= (cnt == count_to);
         fmin_q <= (cnt == '0);
      end
   end

   assign flag_count_max = force_max ? 1'b1 : fmax_q;
   assign flag_count_min = fmin_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_done_cycle(input int t, input int n);
      return 3 + n * (6 * t + 2);
   endfunction

   // Runs one job from the start cycle until the controller is idle again
   task automatic run_job(input int t, input int n, input int abort_at, input bit noise, input bit force_en);
      int cyc;
      int limit;
      limit = exp_done_cycle(t, n);
      r_load = 0; r_inc = 0; r_dec = 0; r_done = 0; r_busy = 0; r_done_cyc = -1;
      r_excl = 0; r_cto_bad = 0; r_abort_pulse = 0; r_end = -1; r_fin = 0; r_err = 0;
      @(negedge clk);
      sweep_to = WIDTH'(t); num_sweeps = 4'(n); start = 1'b1; abort = 1'b0;
      cyc = 0;
      while (!r_fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (noise && cyc <= limit) begin
            start = 1'($urandom_range(0, 1));
            sweep_to = WIDTH'($urandom);
            num_sweeps = 4'($urandom);
         end else begin
            start = 1'b0;
         end
         abort = (cyc == abort_at);
         #1;
         if (load_en) r_load++;
         if (count_inc) r_inc++;
         if (count_dec) r_dec++;
         if (done) begin r_done++; r_done_cyc = cyc; end
         if (busy) r_busy++;
         if (32'(load_en) + 32'(count_inc) + 32'(count_dec) > 1) r_excl++;
         if (busy && count_to != WIDTH'(t)) r_cto_bad++;
         if (abort && (load_en || count_inc || count_dec || done)) r_abort_pulse++;
         if (force_en && count_inc) force_max = 1'b1;
         if (cyc > 1 && !busy) begin
            r_fin = 1;
            r_end = cyc;
            r_err = 32'(err);
         end
      end
      start = 1'b0; abort = 1'b0; force_max = 1'b0;
      check_eq("job_terminates", 32'(r_fin), 1);
   endtask

   task automatic check_normal(input int t, input int n, input bit noise);
      run_job(t, n, -1, noise, 1'b0);
      check_eq("load_pulses", r_load, 1);
      check_eq("inc_pulses", r_inc, n * t);
      check_eq("dec_pulses", r_dec, n * t);
      check_eq("done_pulses", r_done, 1);
      check_eq("done_cycle", r_done_cyc, exp_done_cycle(t, n));
      check_eq("busy_cycles", r_busy, exp_done_cycle(t, n));
      check_eq("pulse_exclusive", r_excl, 0);
      check_eq("count_to_held", r_cto_bad, 0);
      check_eq("final_counter", 32'(cnt), 0);
      check_eq("err_clear", r_err, 0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      check_eq("reset_outputs", {26'd0, load_en, count_inc, count_dec, busy, done, err}, 0);
      check_eq("reset_count_to", 32'(count_to), 0);
      #20 reset = 1'b0;

      // Reference job: ceiling 2, one sweep, done in cycle 17
      check_normal(2, 1, 1'b0);
      // Zero ceiling, three sweeps
      check_normal(0, 3, 1'b0);
      // Zero sweeps: done in cycle 3
      check_normal(5, 0, 1'b0);

      // Abort in the second UP_STEP (cycle 7) of a ceiling-5 job
      run_job(5, 2, 7, 1'b0, 1'b0);
      check_eq("abort_no_pulse", r_abort_pulse, 0);
      check_eq("abort_inc_pulses", r_inc, 1);
      check_eq("abort_no_done", r_done, 0);
      check_eq("abort_idle_next", r_end, 8);
      check_normal(3, 2, 1'b0);

      // Randomized jobs, with start re-asserted while busy
      for (int i = 0; i < 8; i++) begin
         check_normal(int'($urandom_range(0, 15)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      end
      check_normal(15, 2, 1'b1);

      // Ceiling flag stuck high after the first increment
      run_job(4, 1, -1, 1'b0, 1'b1);
`ifdef CNT_SHADOW_CHECK_EN
      check_eq("shadow_err_set", r_err, 1);
      check_eq("shadow_no_done", r_done, 0);
      check_eq("shadow_idle_after", r_end, 7);
`else
      check_eq("noshadow_err_zero", r_err, 0);
      check_eq("noshadow_done", r_done, 1);
`endif

      // Reset asserted between clock edges in the middle of a sweep
      @(negedge clk);
      sweep_to = 4'd6; num_sweeps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      #2;
      check_eq("busy_before_reset", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check_eq("async_reset_outputs", {26'd0, load_en, count_inc, count_dec, busy, done, err}, 0);
      check_eq("async_reset_count_to", 32'(count_to), 0);
      @(negedge clk);
      reset = 1'b0;
      check_normal(1, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL clear immediately on reset assertion.
REQ-002 Parameter: WIDTH, default 4, counter value width.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 start  in  1  request one sweep job; sampled in IDLE only.
REQ-006 abort  in  1  cancel the current job.
REQ-007 sweep_to  in  WIDTH  sweep ceiling; latched at start.
REQ-008 num_sweeps  in  4  number of up/down sweeps; latched at start.
REQ-009 flag_count_max  in  1  counter-at-ceiling flag, registered downstream.
REQ-010 flag_count_min  in  1  counter-at-zero flag, registered downstream.
REQ-011 count_to  out  WIDTH  ceiling driven to the counter (latched sweep_to).
REQ-012 load_en  out  1  one-cycle load pulse.
REQ-013 count_inc  out  1  one-cycle increment pulse.
REQ-014 count_dec  out  1  one-cycle decrement pulse.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle job-complete pulse.
REQ-017 err  out  1  sticky flag/shadow mismatch indication.

Function
REQ-018 States SHALL be: IDLE, LOAD, WAIT, UP_CHK, UP_STEP, DN_CHK, DN_STEP, DONE.
REQ-019 In IDLE with start=1, the block SHALL latch sweep_to and num_sweeps, clear err, and go to LOAD; start in any other state SHALL be ignored.
REQ-020 LOAD SHALL assert load_en for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL last one cycle (flag settling: one edge for the counter update, one edge for the flag register), then go to UP_CHK after LOAD/UP_STEP and to DN_CHK after DN_STEP.
REQ-022 After LOAD, if the latched num_sweeps=0, the block SHALL go from WAIT directly to DONE.
REQ-023 UP_CHK: flag_count_max=1 SHALL go to DN_CHK; otherwise it SHALL go to UP_STEP.
REQ-024 UP_STEP SHALL assert count_inc for one cycle, then go to WAIT.
REQ-025 DN_CHK: flag_count_min=0 SHALL go to DN_STEP; otherwise it SHALL decrement the remaining-sweep count and go to DONE if the count reaches 0, else to UP_CHK.
REQ-026 DN_STEP SHALL assert count_dec for one cycle, then go to WAIT.
REQ-027 count_inc, count_dec and load_en SHALL be mutually exclusive and never high in the same cycle.
REQ-028 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-029 sweep_to=0 SHALL be legal: both flags are set, each sweep costs UP_CHK plus DN_CHK, and no step pulses are issued.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse, and SHALL suppress any step or load pulse in that cycle; abort has priority over start.
REQ-031 count_to SHALL hold the latched sweep_to value until the next accepted start.

Reset
REQ-032 On reset: state=IDLE, count_to=0, load_en=count_inc=count_dec=0, busy=0, done=0, err=0, and the internal counters SHALL clear.

Configuration
REQ-033 Macro CNT_SHADOW_CHECK_EN defined: the block SHALL keep a shadow position (0 at LOAD, +1 per inc, -1 per dec).
REQ-034 With CNT_SHADOW_CHECK_EN, in every CHK state the block SHALL compare flag_count_max against (shadow==count_to) and flag_count_min against (shadow==0).
REQ-035 With CNT_SHADOW_CHECK_EN, on a mismatch the block SHALL set err (sticky until the next accepted start) and go to IDLE without a done pulse.
REQ-036 Macro CNT_SHADOW_CHECK_EN undefined: no shadow logic SHALL exist, err SHALL be tied 0, and the port SHALL remain present.

Verification
REQ-037 Paired with the up/down counter, reset, then start with sweep_to=2, num_sweeps=1 (start sampled in cycle 0) -> load_en in cycle 1, 2 inc pulses, 2 dec pulses, done in cycle 17, busy high in cycles 1-17.
REQ-038 sweep_to=0, num_sweeps=3 -> one load_en pulse, zero inc/dec pulses, done pulse, final counter value 0.
REQ-039 num_sweeps=0 -> load_en pulse, done pulse in cycle 3, no step pulses.
REQ-040 abort during the second UP_STEP of sweep_to=5 -> no inc pulse in that cycle, IDLE next cycle, no done pulse; a new start is then accepted normally.
REQ-041 start re-asserted while busy -> ignored; count_to and the latched num_sweeps stay unchanged.
REQ-042 With CNT_SHADOW_CHECK_EN, flag_count_max forced 1 after the first inc with sweep_to=4 -> err=1, no done pulse, busy=0 on the next cycle; without the macro -> err stays 0.
REQ-043 Assert reset mid-sweep -> all outputs 0 immediately, without waiting for a clock edge.
